// File: rtl/sha1_w_sched.sv
// SHA-1 message-schedule generator.
// Loads one 512-bit block as sixteen 32-bit words, then streams W[0..79]
// to the round datapath over a valid/ready port. A 16-entry circular
// buffer holds the sliding window W[t-16..t-1]; words for t>=16 are
// formed combinationally and written back over the oldest entry.
// Optional build macro: SHA1_WS_KOUT_EN adds the round-constant output k.
module sha1_w_sched (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [31:0] w,
    output logic [6:0]  round,
`ifdef SHA1_WS_KOUT_EN
    output logic [31:0] k,
`endif
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  lc_q, lc_d;
    logic [6:0]  t_q, t_d;
    logic        done_q, done_d;
    logic [31:0] buf_q [16];

    // Buffer write port, shared between loading and schedule write-back.
    logic        wr_en;
    logic [3:0]  wr_idx;
    logic [31:0] wr_data;

    // Window taps, all modulo 16 so they wrap around the circular buffer.
    logic [3:0]  idx_cur, idx_m3, idx_m8, idx_m14;
    logic [31:0] mix;
    logic [31:0] w_calc;
    logic        in_run;

    assign in_run  = (state_q == ST_RUN);
    assign idx_cur = t_q[3:0];
    assign idx_m3  = t_q[3:0] - 4'd3;
    assign idx_m8  = t_q[3:0] - 4'd8;
    assign idx_m14 = t_q[3:0] - 4'd14;

    // Schedule word for the current round: raw block word for t<16,
    // otherwise the XOR of the four taps rotated left by one.
    always_comb begin
        mix = buf_q[idx_m3] ^ buf_q[idx_m8] ^ buf_q[idx_m14] ^ buf_q[idx_cur];
        if (t_q < 7'd16) begin
            w_calc = buf_q[idx_cur];
        end else begin
            w_calc = {mix[30:0], mix[31]};
        end
    end

    assign in_ready = !in_run;
    assign w_valid  = in_run;
    assign w        = in_run ? w_calc : 32'd0;
    assign round    = in_run ? t_q : 7'd0;
    assign done     = done_q;

`ifdef SHA1_WS_KOUT_EN
    // Round constant selected by the current round; zero outside RUN.
    always_comb begin
        k = 32'd0;
        if (in_run) begin
            if (t_q < 7'd20) begin
                k = 32'h5A827999;
            end else if (t_q < 7'd40) begin
                k = 32'h6ED9EBA1;
            end else if (t_q < 7'd60) begin
                k = 32'h8F1BBCDC;
            end else begin
                k = 32'hCA62C1D6;
            end
        end
    end
`endif

    // Next-state logic: load sequencing, round stepping and buffer writes.
    always_comb begin
        state_d = state_q;
        lc_d    = lc_q;
        t_d     = t_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = lc_q;
        wr_data = in_data;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    wr_en   = 1'b1;
                    wr_idx  = 4'd0;
                    lc_d    = 4'd1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    wr_en  = 1'b1;
                    wr_idx = lc_q;
                    lc_d   = lc_q + 4'd1;
                    if (lc_q == 4'd15) begin
                        state_d = ST_RUN;
                        t_d     = 7'd0;
                        lc_d    = 4'd0;
                    end
                end
            end
            ST_RUN: begin
                if (w_ready) begin
                    // Words past 15 replace W[t-16], which is no longer needed.
                    if (t_q >= 7'd16) begin
                        wr_en   = 1'b1;
                        wr_idx  = idx_cur;
                        wr_data = w_calc;
                    end
                    t_d = t_q + 7'd1;
                    if (t_q == 7'd79) begin
                        state_d = ST_IDLE;
                        t_d     = 7'd0;
                        lc_d    = 4'd0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                lc_d    = 4'd0;
                t_d     = 7'd0;
            end
        endcase
    end

    // Control registers; reset discards any partial block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lc_q    <= 4'd0;
            t_q     <= 7'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lc_q    <= lc_d;
            t_q     <= t_d;
            done_q  <= done_d;
        end
    end

    // Circular window buffer, cleared on reset so nothing leaks between blocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= 32'd0;
            end
        end else if (wr_en) begin
            buf_q[wr_idx] <= wr_data;
        end
    end

endmodule

// File: tb/tb_sha1_w_sched.sv
// Directed testbench for sha1_w_sched: "abc" block, output stalls,
// load gaps, mid-run reset and back-to-back blocks.
module tb_sha1_w_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w;
    logic [6:0]  round;
    logic        done;
`ifdef SHA1_WS_KOUT_EN
    logic [31:0] k;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] blk   [16];
    logic [31:0] ref_w [80];
    logic [31:0] got   [80];
    logic [31:0] base  [80];

    sha1_w_sched dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w        (w),
        .round    (round),
`ifdef SHA1_WS_KOUT_EN
        .k        (k),
`endif
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Textbook schedule on a flat 80-word array.
    function automatic void build_ref();
        logic [31:0] x;
        for (int t = 0; t < 16; t++) ref_w[t] = blk[t];
        for (int t = 16; t < 80; t++) begin
            x = ref_w[t-3] ^ ref_w[t-8] ^ ref_w[t-14] ^ ref_w[t-16];
            ref_w[t] = {x[30:0], x[31]};
        end
    endfunction

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'd0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    task automatic load_block(input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int j = 0; j < g; j++) begin
                    in_valid = 1'b0;
                    tick();
                end
            end
            chk("load_in_ready", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = blk[i];
            tick();
            if (i < 15) chk("load_no_wvalid", 32'(w_valid), 32'd0);
        end
        in_valid = 1'b0;
        in_data  = 32'd0;
        chk("run_entry_valid", 32'(w_valid), 32'd1);
        chk("run_entry_round", 32'(round), 32'd0);
    endtask

    // Consumes the 80 words into got[], optionally stalling and poking in_valid.
    // Returns at the negedge of the done cycle.
    task automatic run_block(input int stall_at, input int stall_len, input bit poke_in);
        int idx    = 0;
        int rem    = stall_len;
        int budget = 0;
        logic [31:0] held = 32'd0;
        while (idx < 80 && budget < 1000) begin
            budget++;
            in_valid = poke_in;
            in_data  = 32'hDEADBEEF;
            if (poke_in) chk("run_in_ready", 32'(in_ready), 32'd0);
            chk("run_done_low", 32'(done), 32'd0);
            if (32'(round) == 32'(stall_at) && rem > 0) begin
                w_ready = 1'b0;
                if (rem != stall_len) chk("stall_hold_w", w, held);
                else held = w;
                rem--;
            end else begin
                w_ready = 1'b1;
                chk("run_w_valid", 32'(w_valid), 32'd1);
                chk("run_round", 32'(round), 32'(idx));
                if (stall_len > 0 && idx == stall_at) chk("stall_release_w", w, held);
`ifdef SHA1_WS_KOUT_EN
                if (idx < 20)      chk("k_const", k, 32'h5A827999);
                else if (idx < 40) chk("k_const", k, 32'h6ED9EBA1);
                else if (idx < 60) chk("k_const", k, 32'h8F1BBCDC);
                else               chk("k_const", k, 32'hCA62C1D6);
`endif
                got[idx] = w;
                idx++;
            end
            tick();
        end
        w_ready  = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'd0;
        if (idx < 80) chk("run_timeout_words", 32'(idx), 32'd80);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_w_valid", 32'(w_valid), 32'd0);
        chk("done_in_ready", 32'(in_ready), 32'd1);
        chk("done_round", 32'(round), 32'd0);
        chk("done_w_zero", w, 32'd0);
    endtask

    task automatic cmp_stream(input string tag, input bit against_base);
        for (int i = 0; i < 80; i++) begin
            chk($sformatf("%s_w%0d", tag, i), got[i], against_base ? base[i] : ref_w[i]);
        end
    endtask

    initial begin
        int start;
        int budget;
        logic [31:0] acc;

        reset    = 1'b1;
        in_valid = 1'b0;
        w_ready  = 1'b0;
        in_data  = 32'd0;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_w_valid", 32'(w_valid), 32'd0);
        chk("rst_w", w, 32'd0);
        chk("rst_round", 32'(round), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // "abc" block, no stalls.
        set_abc();
        build_ref();
        start = cyc;
        load_block(1'b0);
        run_block(-1, 0, 1'b0);
        chk("abc_block_cycles", 32'(cyc - start), 32'd96);
        chk("abc_w0", got[0], 32'h61626380);
        chk("abc_w16", got[16], 32'hC2C4C700);
        chk("abc_w17", got[17], 32'h00000000);
        chk("abc_w18", got[18], 32'h00000030);
        chk("abc_w19", got[19], 32'h85898E01);
        cmp_stream("abc_ref", 1'b0);
        for (int i = 0; i < 80; i++) base[i] = got[i];
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);

        // Backpressure at round 17, then at round 3.
        load_block(1'b0);
        run_block(17, 5, 1'b0);
        cmp_stream("stall17", 1'b1);
        tick();
        load_block(1'b0);
        run_block(3, 5, 1'b0);
        cmp_stream("stall3", 1'b1);
        tick();

        // Load gaps plus in_valid held high during RUN.
        load_block(1'b1);
        run_block(-1, 0, 1'b1);
        cmp_stream("gaps", 1'b1);
        tick();

        // Reset at round 40.
        load_block(1'b0);
        w_ready = 1'b1;
        budget  = 0;
        while (round != 7'd40 && budget < 100) begin
            budget++;
            tick();
        end
        chk("reach_round40", 32'(round), 32'd40);
        reset = 1'b1;
        #1;
        chk("midrst_w_valid", 32'(w_valid), 32'd0);
        chk("midrst_round", 32'(round), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_w", w, 32'd0);
        w_ready = 1'b0;
        tick();
        reset = 1'b0;
        load_block(1'b0);
        run_block(-1, 0, 1'b0);
        chk("postrst_w16", got[16], 32'hC2C4C700);
        cmp_stream("postrst", 1'b1);

        // Back-to-back: all-zero block loaded starting in the done cycle.
        for (int i = 0; i < 16; i++) blk[i] = 32'd0;
        load_block(1'b0);
        run_block(-1, 0, 1'b0);
        acc = 32'd0;
        for (int i = 0; i < 80; i++) acc = acc | got[i];
        chk("b2b_zero_stream", acc, 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
